// File: rtl/wb_multi_lane.sv
// Purpose: N-lane write-back stage; captures per-lane results, drives per-lane register-file write and bypass ports.
// Latency: data captured at one edge is written and bypassed in the following cycle while SENDING with the register file ready.
// Backpressure: regFileWriteReady=0 in SENDING stalls: no writes, no bypass, counter holds, curPipReadyToRcv drops.
module wb_multi_lane #(
   parameter int XLEN    = 32,
   parameter int REG_IDX = 5,
   parameter int LANES   = 2,
   parameter int CNT_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       startSig,
   input  logic                       beforePipReadyToSend,
   input  logic                       nextPipReadyToRcv,
   input  logic                       regFileWriteReady,
   input  logic [LANES-1:0]           wb_valid,
   input  logic [LANES*REG_IDX-1:0]   wb_idx,
   input  logic [LANES*XLEN-1:0]      wb_val,
   input  logic [LANES-1:0]           wb_en_valid,
   input  logic [LANES-1:0]           wb_en_idx,
   input  logic [LANES-1:0]           wb_en_data,
   output logic                       curPipReadyToRcv,
   output logic                       curPipReadyToSend,
   output logic [LANES*REG_IDX-1:0]   bp_idx,
   output logic [LANES*XLEN-1:0]      bp_val,
   output logic [LANES*REG_IDX-1:0]   regFileWriteIdx,
   output logic [LANES*XLEN-1:0]      regFileWriteVal,
   output logic [LANES-1:0]           regFileWriteEn,
   output logic [CNT_W-1:0]           commitCount
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_BEF = 2'd1;
   localparam logic [1:0] SENDING  = 2'd2;

   logic [1:0]               state_q;
   logic [1:0]               state_d;
   logic [LANES-1:0]         cap_valid;
   logic [LANES*REG_IDX-1:0] cap_idx;
   logic [LANES*XLEN-1:0]    cap_val;
   logic [LANES-1:0]         cand;
   logic [LANES-1:0]         eff;
   logic [CNT_W-1:0]         pop;
   logic [CNT_W-1:0]         cnt_q;
   logic                     send_now;

   // Per-field capture: each lane field loads only under its own enable, whatever the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_valid <= '0;
         cap_idx   <= '0;
         cap_val   <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (wb_en_valid[k]) cap_valid[k] <= wb_valid[k];
            if (wb_en_idx[k])   cap_idx[k*REG_IDX +: REG_IDX] <= wb_idx[k*REG_IDX +: REG_IDX];
            if (wb_en_data[k])  cap_val[k*XLEN +: XLEN] <= wb_val[k*XLEN +: XLEN];
         end
      end
   end

   // Next-state logic for the IDLE / WAIT_BEF / SENDING handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (startSig) state_d = beforePipReadyToSend ? SENDING : WAIT_BEF;
         end
         WAIT_BEF: begin
            state_d = beforePipReadyToSend ? SENDING : WAIT_BEF;
         end
         SENDING: begin
            if (regFileWriteReady && nextPipReadyToRcv)
               state_d = beforePipReadyToSend ? SENDING : WAIT_BEF;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   assign send_now          = (state_q == SENDING) && regFileWriteReady;
   assign curPipReadyToSend = send_now;
   assign curPipReadyToRcv  = (state_q == WAIT_BEF) || (send_now && nextPipReadyToRcv);

   // Candidate lanes, then drop any lane shadowed by a younger (higher) lane writing the same index.
   always_comb begin
      cand = '0;
      eff  = '0;
      for (int k = 0; k < LANES; k++) begin
         cand[k] = send_now && cap_valid[k] && (cap_idx[k*REG_IDX +: REG_IDX] != '0);
      end
      for (int k = 0; k < LANES; k++) begin
         eff[k] = cand[k];
         for (int j = k + 1; j < LANES; j++) begin
            if (cand[j] && (cap_idx[j*REG_IDX +: REG_IDX] == cap_idx[k*REG_IDX +: REG_IDX]))
               eff[k] = 1'b0;
         end
      end
   end

   // Bypass carries only the lanes that actually commit; everything else reads as zero.
   always_comb begin
      bp_idx = '0;
      bp_val = '0;
      for (int k = 0; k < LANES; k++) begin
         if (eff[k]) begin
            bp_idx[k*REG_IDX +: REG_IDX] = cap_idx[k*REG_IDX +: REG_IDX];
            bp_val[k*XLEN +: XLEN]       = cap_val[k*XLEN +: XLEN];
         end
      end
   end

   assign regFileWriteEn  = eff;
   assign regFileWriteIdx = cap_idx;
   assign regFileWriteVal = cap_val;

   // Number of lanes committing this cycle.
   always_comb begin
      pop = '0;
      for (int k = 0; k < LANES; k++) begin
         pop = pop + CNT_W'(eff[k]);
      end
   end

   // Committed-write counter; wraps silently at 2^CNT_W.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_q + pop;
   end

   assign commitCount = cnt_q;

endmodule

// File: tb/tb_wb_multi_lane.sv
// Bench for wb_multi_lane: directed table, async reset sequence, then random traffic vs a reference model.
// Model tracks state by name, resolves lane conflicts with a last-writer-wins index map.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_wb_multi_lane;

   localparam int XLEN  = 32;
   localparam int RIDX  = 5;
   localparam int LANES = 2;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   logic startSig, beforePipReadyToSend, nextPipReadyToRcv, regFileWriteReady;
   logic [LANES-1:0]      wb_valid, wb_en_valid, wb_en_idx, wb_en_data;
   logic [LANES*RIDX-1:0] wb_idx;
   logic [LANES*XLEN-1:0] wb_val;
   logic                  curPipReadyToRcv, curPipReadyToSend;
   logic [LANES*RIDX-1:0] bp_idx, regFileWriteIdx;
   logic [LANES*XLEN-1:0] bp_val, regFileWriteVal;
   logic [LANES-1:0]      regFileWriteEn;
   logic [CNT_W-1:0]      commitCount;

   int checks = 0;
   int failures = 0;

   wb_multi_lane #(.XLEN(XLEN), .REG_IDX(RIDX), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .startSig(startSig),
      .beforePipReadyToSend(beforePipReadyToSend), .nextPipReadyToRcv(nextPipReadyToRcv),
      .regFileWriteReady(regFileWriteReady),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
      .wb_en_valid(wb_en_valid), .wb_en_idx(wb_en_idx), .wb_en_data(wb_en_data),
      .curPipReadyToRcv(curPipReadyToRcv), .curPipReadyToSend(curPipReadyToSend),
      .bp_idx(bp_idx), .bp_val(bp_val),
      .regFileWriteIdx(regFileWriteIdx), .regFileWriteVal(regFileWriteVal),
      .regFileWriteEn(regFileWriteEn), .commitCount(commitCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_WAIT, M_SEND} mstate_t;
   mstate_t         m_state;
   bit              m_vld[LANES];
   int              m_idx[LANES];
   logic [XLEN-1:0] m_val[LANES];
   int              m_cnt;

   logic                  e_rts, e_rtr;
   logic [LANES-1:0]      e_we;
   logic [LANES*RIDX-1:0] e_bpi, e_wi;
   logic [LANES*XLEN-1:0] e_bpv, e_wv;

   task automatic model_reset();
      m_state = M_IDLE;
      m_cnt   = 0;
      for (int k = 0; k < LANES; k++) begin
         m_vld[k] = 1'b0; m_idx[k] = 0; m_val[k] = '0;
      end
   endtask

   task automatic model_expect();
      int owner[1 << RIDX];
      for (int i = 0; i < (1 << RIDX); i++) owner[i] = -1;
      e_rts = (m_state == M_SEND) && regFileWriteReady;
      e_rtr = (m_state == M_WAIT) || (e_rts && nextPipReadyToRcv);
      // program order: later lanes overwrite earlier owners of the same register
      for (int k = 0; k < LANES; k++)
         if (e_rts && m_vld[k] && m_idx[k] != 0) owner[m_idx[k]] = k;
      e_we = '0; e_bpi = '0; e_bpv = '0;
      for (int k = 0; k < LANES; k++) begin
         e_wi[k*RIDX +: RIDX] = RIDX'(m_idx[k]);
         e_wv[k*XLEN +: XLEN] = m_val[k];
         if (e_rts && m_vld[k] && m_idx[k] != 0 && owner[m_idx[k]] == k) begin
            e_we[k] = 1'b1;
            e_bpi[k*RIDX +: RIDX] = RIDX'(m_idx[k]);
            e_bpv[k*XLEN +: XLEN] = m_val[k];
         end
      end
   endtask

   task automatic model_update();
      if (!rst) begin
         model_reset();
      end else begin
         model_expect();
         m_cnt = (m_cnt + $countones(e_we)) % (1 << CNT_W);
         case (m_state)
            M_IDLE: if (startSig) m_state = beforePipReadyToSend ? M_SEND : M_WAIT;
            M_WAIT: m_state = beforePipReadyToSend ? M_SEND : M_WAIT;
            default: if (regFileWriteReady && nextPipReadyToRcv)
                        m_state = beforePipReadyToSend ? M_SEND : M_WAIT;
         endcase
         for (int k = 0; k < LANES; k++) begin
            if (wb_en_valid[k]) m_vld[k] = wb_valid[k];
            if (wb_en_idx[k])   m_idx[k] = int'(wb_idx[k*RIDX +: RIDX]);
            if (wb_en_data[k])  m_val[k] = wb_val[k*XLEN +: XLEN];
         end
      end
   endtask

   task automatic check_model();
      model_expect();
      chk("m_rts",  128'(curPipReadyToSend), 128'(e_rts));
      chk("m_rtr",  128'(curPipReadyToRcv),  128'(e_rtr));
      chk("m_we",   128'(regFileWriteEn),    128'(e_we));
      chk("m_bpi",  128'(bp_idx),            128'(e_bpi));
      chk("m_bpv",  128'(bp_val),            128'(e_bpv));
      chk("m_wi",   128'(regFileWriteIdx),   128'(e_wi));
      chk("m_wv",   128'(regFileWriteVal),   128'(e_wv));
      chk("m_cnt",  128'(commitCount),       128'(m_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rts"}, 128'(curPipReadyToSend), 128'(0));
      chk({tag, "_rtr"}, 128'(curPipReadyToRcv),  128'(0));
      chk({tag, "_we"},  128'(regFileWriteEn),    128'(0));
      chk({tag, "_bpi"}, 128'(bp_idx),            128'(0));
      chk({tag, "_bpv"}, 128'(bp_val),            128'(0));
      chk({tag, "_wi"},  128'(regFileWriteIdx),   128'(0));
      chk({tag, "_wv"},  128'(regFileWriteVal),   128'(0));
      chk({tag, "_cnt"}, 128'(commitCount),       128'(0));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic st, bef, nxt, rdy;
      logic [1:0] vld, en;
      logic [4:0] i0, i1;
      logic [31:0] v0, v1;
      logic [1:0] e_we;
      logic e_rts, e_rtr;
      logic [9:0] e_bpi;
      logic [63:0] e_bpv;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic bef, input logic nxt, input logic rdy,
                               input logic [1:0] vld, input logic [1:0] en,
                               input logic [4:0] i0, input logic [31:0] v0,
                               input logic [4:0] i1, input logic [31:0] v1,
                               input logic [1:0] we, input logic rts, input logic rtr,
                               input logic [9:0] bpi, input logic [63:0] bpv, input logic [3:0] cnt);
      vec_t r;
      r.st = st; r.bef = bef; r.nxt = nxt; r.rdy = rdy; r.vld = vld; r.en = en;
      r.i0 = i0; r.v0 = v0; r.i1 = i1; r.v1 = v1;
      r.e_we = we; r.e_rts = rts; r.e_rtr = rtr; r.e_bpi = bpi; r.e_bpv = bpv; r.e_cnt = cnt;
      return r;
   endfunction

   initial begin
      logic [9:0]  held_i;
      logic [63:0] held_v;
      held_i = {5'd10, 5'd9};
      held_v = {32'hA, 32'h9};

      // start + first capture; nothing commits while IDLE
      tbl.push_back(mk(1'b1,1'b1,1'b1,1'b1, 2'b11,2'b11, 5'd3,32'hAAAA, 5'd5,32'h5555,
                       2'b00,1'b0,1'b0, 10'd0, 64'd0, 4'd0));
      // basic two-lane commit; conflict pair captured
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b11,2'b11, 5'd7,32'h1, 5'd7,32'h2,
                       2'b11,1'b1,1'b1, {5'd5,5'd3}, {32'h5555,32'hAAAA}, 4'd0));
      // conflict resolved to lane1; capture x0 on lane0, invalid lane1
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b01,2'b11, 5'd0,32'h99, 5'd4,32'h44,
                       2'b10,1'b1,1'b1, {5'd7,5'd0}, {32'h2,32'h0}, 4'd2));
      // x0 / invalid: no writes; capture 9/10
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b11,2'b11, 5'd9,32'h9, 5'd10,32'hA,
                       2'b00,1'b1,1'b1, 10'd0, 64'd0, 4'd3));
      // three stall cycles
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                          2'b00,1'b0,1'b0, 10'd0, 64'd0, 4'd3));
      // release: commit held values
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b11,1'b1,1'b1, held_i, held_v, 4'd3));
      // upstream empty -> WAIT_BEF afterwards
      tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b11,1'b1,1'b1, held_i, held_v, 4'd5));
      tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b00,1'b0,1'b1, 10'd0, 64'd0, 4'd7));
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b00,1'b0,1'b1, 10'd0, 64'd0, 4'd7));
      // back in SENDING: count 7,9,11,13,15 then wraps to 1
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                          2'b11,1'b1,1'b1, held_i, held_v, 4'(7 + 2*i)));
      // downstream not ready: still commits, but cannot accept
      tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b11,1'b1,1'b0, held_i, held_v, 4'd1));
      tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00, 5'd0,32'h0, 5'd0,32'h0,
                       2'b00,1'b0,1'b0, 10'd0, 64'd0, 4'd3));
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b0;
      startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b0; regFileWriteReady = 1'b0;
      wb_valid = '0; wb_idx = '0; wb_val = '0;
      wb_en_valid = '0; wb_en_idx = '0; wb_en_data = '0;
      model_reset();
      #1;
      check_all_zero("reset0");
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int r = 0; r < tbl.size(); r++) begin
         startSig = tbl[r].st; beforePipReadyToSend = tbl[r].bef;
         nextPipReadyToRcv = tbl[r].nxt; regFileWriteReady = tbl[r].rdy;
         wb_valid = tbl[r].vld;
         wb_en_valid = tbl[r].en; wb_en_idx = tbl[r].en; wb_en_data = tbl[r].en;
         wb_idx = {tbl[r].i1, tbl[r].i0};
         wb_val = {tbl[r].v1, tbl[r].v0};
         @(negedge clk);
         chk($sformatf("row%0d_we", r),  128'(regFileWriteEn),    128'(tbl[r].e_we));
         chk($sformatf("row%0d_rts", r), 128'(curPipReadyToSend), 128'(tbl[r].e_rts));
         chk($sformatf("row%0d_rtr", r), 128'(curPipReadyToRcv),  128'(tbl[r].e_rtr));
         chk($sformatf("row%0d_bpi", r), 128'(bp_idx),            128'(tbl[r].e_bpi));
         chk($sformatf("row%0d_bpv", r), 128'(bp_val),            128'(tbl[r].e_bpv));
         chk($sformatf("row%0d_cnt", r), 128'(commitCount),       128'(tbl[r].e_cnt));
         tick();
      end

      // async reset mid-SENDING with valid held lanes
      regFileWriteReady = 1'b1;
      wb_en_valid = '0; wb_en_idx = '0; wb_en_data = '0;
      #1;
      chk("pre_rst_we", 128'(regFileWriteEn), 128'(2'b11));
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      #2 rst = 1'b1;
      startSig = 1'b0; beforePipReadyToSend = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("idle_rtr", 128'(curPipReadyToRcv),  128'(0));
         chk("idle_rts", 128'(curPipReadyToSend), 128'(0));
         check_model();
      end
      tick();

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         startSig             = ($urandom_range(0, 3) == 0);
         beforePipReadyToSend = ($urandom_range(0, 3) != 0);
         nextPipReadyToRcv    = ($urandom_range(0, 3) != 0);
         regFileWriteReady    = ($urandom_range(0, 3) != 0);
         wb_valid    = LANES'($urandom);
         wb_en_valid = LANES'($urandom);
         wb_en_idx   = LANES'($urandom);
         wb_en_data  = LANES'($urandom);
         wb_idx = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         wb_val = {$urandom, $urandom};
         @(negedge clk);
         check_model();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
